// File: rtl/i2c_target_pkg.sv
// Shared types and widths for the I2C target.
package i2c_target_pkg;

  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned NBY_W   = 3;
  localparam int unsigned MAX_NBY = 4;

  // Protocol state of the target
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_AACK      = 3'd2,
    ST_WRITE     = 3'd3,
    ST_WACK      = 3'd4,
    ST_READ      = 3'd5,
    ST_RACK      = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_e;

  // Bus conditions decoded from the synchronized lines
  typedef enum logic [1:0] {
    COND_NONE  = 2'd0,
    COND_START = 2'd1,
    COND_STOP  = 2'd2
  } bus_cond_e;

  // Sub-phase inside an acknowledge slot:
  // first SCL fall (slot begins), 9th SCL rise, second SCL fall (slot ends)
  typedef enum logic [1:0] {
    PH_FALL1 = 2'd0,
    PH_RISE  = 2'd1,
    PH_FALL2 = 2'd2
  } ack_ph_e;

  // Byte counter that sticks at MAX_NBY
  function automatic logic [NBY_W-1:0] sat_inc(input logic [NBY_W-1:0] n);
    return (n >= NBY_W'(MAX_NBY)) ? n : n + NBY_W'(1);
  endfunction

endpackage

// File: rtl/i2c_target_if.sv
// Bus and local-side signals of the I2C target.
interface i2c_target_if;
  import i2c_target_pkg::*;

  logic                    scl_i;
  logic                    sda_i;
  logic                    sda_oe_o;
  logic [WORD_W-1:0]       tx_data_i;
  logic                    tx_load_o;
  logic [WORD_W-1:0]       rx_data_o;
  logic [NBY_W-1:0]        rx_nby_o;
  logic                    rx_done_o;
  logic                    busy_o;

  modport slave (
    input  scl_i, sda_i, tx_data_i,
    output sda_oe_o, tx_load_o, rx_data_o, rx_nby_o, rx_done_o, busy_o
  );

  modport master (
    output scl_i, sda_i, tx_data_i,
    input  sda_oe_o, tx_load_o, rx_data_o, rx_nby_o, rx_done_o, busy_o
  );

endinterface

// File: rtl/i2c_target_line_sync.sv
// SCL/SDA synchronizer with edge and START/STOP detection.
module i2c_line_sync
  import i2c_target_pkg::*;
#(
  parameter int unsigned SYNC_LEN = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      scl_i,
  input  logic      sda_i,
  output logic      scl_rise_c_o,
  output logic      scl_fall_c_o,
  output logic      sda_c_o,
  output bus_cond_e cond_c_o
);

  logic [SYNC_LEN-1:0] scl_sync_q;
  logic [SYNC_LEN-1:0] sda_sync_q;
  logic                scl_prev_q;
  logic                sda_prev_q;
  logic                scl_s;
  logic                sda_s;

  // Synchronizer chains plus one history stage; reset to idle-high bus
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_LEN-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_LEN-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s        = scl_sync_q[SYNC_LEN-1];
  assign sda_s        = sda_sync_q[SYNC_LEN-1];
  assign scl_rise_c_o = scl_s & ~scl_prev_q;
  assign scl_fall_c_o = ~scl_s & scl_prev_q;
  assign sda_c_o      = sda_s;

  // SDA moving while SCL is held high marks START (fall) or STOP (rise)
  always_comb begin
    cond_c_o = COND_NONE;
    if (scl_s && scl_prev_q) begin
      if (sda_prev_q && !sda_s) begin
        cond_c_o = COND_START;
      end else if (!sda_prev_q && sda_s) begin
        cond_c_o = COND_STOP;
      end
    end
  end

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, up to 4-byte write capture, 32-bit read source.
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [ADDR_W-1:0] TGT_ADDR = 7'h50,
  parameter int unsigned       SYNC_LEN = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  i2c_target_if.slave  bus
);

  logic      scl_rise;
  logic      scl_fall;
  logic      sda_s;
  bus_cond_e cond;

  state_e              state_q,   state_d;
  ack_ph_e             ph_q,      ph_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]   byte_sr_q, byte_sr_d;
  logic [WORD_W-1:0]   tx_sr_q,   tx_sr_d;
  logic                wr_xfer_q, wr_xfer_d;
  logic                oe_q,      oe_d;
  logic                tx_load_q, tx_load_d;
  logic [WORD_W-1:0]   rx_data_q, rx_data_d;
  logic [NBY_W-1:0]    rx_nby_q,  rx_nby_d;
  logic                rx_done_q, rx_done_d;
  logic                busy_q,    busy_d;

  logic [BYTE_W-1:0]   byte_in;
  logic [WORD_W-1:0]   tx_src;

  i2c_line_sync #(
    .SYNC_LEN (SYNC_LEN)
  ) u_sync (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .scl_i        (bus.scl_i),
    .sda_i        (bus.sda_i),
    .scl_rise_c_o (scl_rise),
    .scl_fall_c_o (scl_fall),
    .sda_c_o      (sda_s),
    .cond_c_o     (cond)
  );

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      ph_q      <= PH_FALL1;
      bit_cnt_q <= '0;
      byte_sr_q <= '0;
      tx_sr_q   <= '0;
      wr_xfer_q <= 1'b0;
      oe_q      <= 1'b0;
      tx_load_q <= 1'b0;
      rx_data_q <= '0;
      rx_nby_q  <= '0;
      rx_done_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      bit_cnt_q <= bit_cnt_d;
      byte_sr_q <= byte_sr_d;
      tx_sr_q   <= tx_sr_d;
      wr_xfer_q <= wr_xfer_d;
      oe_q      <= oe_d;
      tx_load_q <= tx_load_d;
      rx_data_q <= rx_data_d;
      rx_nby_q  <= rx_nby_d;
      rx_done_q <= rx_done_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state and output logic; START/STOP take priority over every state
  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    bit_cnt_d = bit_cnt_q;
    byte_sr_d = byte_sr_q;
    tx_sr_d   = tx_load_q ? bus.tx_data_i : tx_sr_q;
    wr_xfer_d = wr_xfer_q;
    oe_d      = oe_q;
    tx_load_d = 1'b0;
    rx_data_d = rx_data_q;
    rx_nby_d  = rx_nby_q;
    rx_done_d = 1'b0;
    busy_d    = busy_q;
    byte_in   = {byte_sr_q[BYTE_W-2:0], sda_s};
    // Word just captured this cycle may be needed before tx_sr_q settles
    tx_src    = tx_load_q ? bus.tx_data_i : tx_sr_q;

    if (cond != COND_NONE) begin
      rx_done_d = wr_xfer_q && (rx_nby_q != '0);
      wr_xfer_d = 1'b0;
      oe_d      = 1'b0;
      ph_d      = PH_FALL1;
      byte_sr_d = '0;
      if (cond == COND_STOP) begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end else begin
        state_d   = ST_ADDR;
        bit_cnt_d = CNT_W'(BYTE_W - 1);
        busy_d    = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          oe_d = 1'b0;
        end

        ST_ADDR: begin
          if (scl_rise) begin
            byte_sr_d = byte_in;
            bit_cnt_d = bit_cnt_q - CNT_W'(1);
            if (bit_cnt_q == '0) begin
              if (byte_in[BYTE_W-1:1] == TGT_ADDR) begin
                state_d = ST_AACK;
                ph_d    = PH_FALL1;
                if (!byte_in[0]) begin
                  rx_data_d = '0;
                  rx_nby_d  = '0;
                  wr_xfer_d = 1'b1;
                end
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end
          end
        end

        // byte_sr_q[0] still holds the R/W bit here
        ST_AACK: begin
          if (ph_q == PH_FALL1 && scl_fall) begin
            oe_d = 1'b1;
            ph_d = PH_RISE;
          end else if (ph_q == PH_RISE && scl_rise) begin
            tx_load_d = byte_sr_q[0];
            ph_d      = PH_FALL2;
          end else if (ph_q == PH_FALL2 && scl_fall) begin
            bit_cnt_d = CNT_W'(BYTE_W - 1);
            ph_d      = PH_FALL1;
            if (byte_sr_q[0]) begin
              state_d = ST_READ;
              oe_d    = ~tx_src[WORD_W-1];
            end else begin
              state_d = ST_WRITE;
              oe_d    = 1'b0;
            end
          end
        end

        ST_WRITE: begin
          if (scl_rise) begin
            byte_sr_d = byte_in;
            bit_cnt_d = bit_cnt_q - CNT_W'(1);
            if (bit_cnt_q == '0) begin
              state_d   = ST_WACK;
              ph_d      = PH_FALL1;
              rx_data_d = {rx_data_q[WORD_W-BYTE_W-1:0], byte_in};
              rx_nby_d  = sat_inc(rx_nby_q);
            end
          end
        end

        ST_WACK: begin
          if (ph_q == PH_FALL1 && scl_fall) begin
            oe_d = 1'b1;
            ph_d = PH_RISE;
          end else if (ph_q == PH_RISE && scl_rise) begin
            ph_d = PH_FALL2;
          end else if (ph_q == PH_FALL2 && scl_fall) begin
            oe_d      = 1'b0;
            state_d   = ST_WRITE;
            bit_cnt_d = CNT_W'(BYTE_W - 1);
            ph_d      = PH_FALL1;
          end
        end

        // Shift one bit per rising edge; the next MSB goes out on the falling edge
        ST_READ: begin
          if (scl_fall) begin
            oe_d = ~tx_sr_q[WORD_W-1];
          end else if (scl_rise) begin
            tx_sr_d   = {tx_sr_q[WORD_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q - CNT_W'(1);
            if (bit_cnt_q == '0) begin
              state_d = ST_RACK;
              ph_d    = PH_FALL1;
            end
          end
        end

        ST_RACK: begin
          if (ph_q == PH_FALL1 && scl_fall) begin
            oe_d = 1'b0;
            ph_d = PH_RISE;
          end else if (ph_q == PH_RISE && scl_rise) begin
            if (sda_s) begin
              state_d = ST_WAIT_STOP;
            end else begin
              ph_d = PH_FALL2;
            end
          end else if (ph_q == PH_FALL2 && scl_fall) begin
            state_d   = ST_READ;
            oe_d      = ~tx_sr_q[WORD_W-1];
            bit_cnt_d = CNT_W'(BYTE_W - 1);
            ph_d      = PH_FALL1;
          end
        end

        ST_WAIT_STOP: begin
          oe_d = 1'b0;
        end

        default: begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  assign bus.sda_oe_o  = oe_q;
  assign bus.tx_load_o = tx_load_q;
  assign bus.rx_data_o = rx_data_q;
  assign bus.rx_nby_o  = rx_nby_q;
  assign bus.rx_done_o = rx_done_q;
  assign bus.busy_o    = busy_q;

endmodule
